// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter for the core's single memory request channel: allocates a TID per
// transaction, caps in-flight transactions and steers responses back to their owners by TID.
module mem_req_arbiter #(
   parameter int NR_REQ          = 3,
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 64,
   parameter int TID_W           = 3,
   parameter int MAX_OUTSTANDING = 7
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NR_REQ-1:0]        req_valid_i,
   output logic [NR_REQ-1:0]        req_ready_o,
   input  logic [NR_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NR_REQ-1:0]        req_we_i,
   input  logic [NR_REQ*DATA_W-1:0] req_data_i,
   input  logic [NR_REQ-1:0]        req_last_i,
   output logic                     mem_valid_o,
   input  logic                     mem_ready_i,
   output logic [ADDR_W-1:0]        mem_addr_o,
   output logic                     mem_we_o,
   output logic [DATA_W-1:0]        mem_data_o,
   output logic                     mem_last_o,
   output logic [TID_W-1:0]         mem_tid_o,
   input  logic                     rsp_valid_i,
   input  logic [TID_W-1:0]         rsp_tid_i,
   input  logic                     rsp_last_i,
   output logic [NR_REQ-1:0]        rsp_valid_o,
   output logic [TID_W:0]           outstanding_o,
   output logic                     unexp_rsp_o
);

   localparam int NTID  = 1 << TID_W;
   localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
   localparam logic [TID_W:0] MAX_OUT_C = (TID_W + 1)'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

   state_t           state_r;
   logic [PTR_W-1:0] rr_ptr_r;
   logic [PTR_W-1:0] burst_req_r;
   logic [TID_W-1:0] burst_tid_r;
   logic [NTID-1:0]  tid_busy_r;
   logic [PTR_W-1:0] tid_owner_r [NTID];
   logic [TID_W:0]   outstanding_r;
   logic             unexp_r;

   logic             free_found_s;
   logic [TID_W-1:0] free_tid_s;
   logic             req_found_s;
   logic [PTR_W-1:0] req_sel_s;
   logic             grant_valid_s;
   logic [PTR_W-1:0] grantee_s;
   logic [TID_W-1:0] grant_tid_s;
   logic             hs_s;
   logic             alloc_s;
   logic             rsp_hit_s;
   logic             free_s;

   function automatic logic [PTR_W-1:0] rr_offset(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NR_REQ) begin
         sum = sum - NR_REQ;
      end else begin
         sum = sum;
      end
      return PTR_W'(sum);
   endfunction

   // Lowest free TID and first valid requester at or after the round-robin pointer.
   always_comb begin
      free_found_s = 1'b0;
      free_tid_s   = '0;
      req_found_s  = 1'b0;
      req_sel_s    = '0;
      for (int t = NTID - 1; t >= 0; t--) begin
         if (!tid_busy_r[t]) begin
            free_found_s = 1'b1;
            free_tid_s   = TID_W'(t);
         end else begin
            free_found_s = free_found_s;
         end
      end
      for (int i = NR_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[rr_offset(rr_ptr_r, i)]) begin
            req_found_s = 1'b1;
            req_sel_s   = rr_offset(rr_ptr_r, i);
         end else begin
            req_found_s = req_found_s;
         end
      end
   end

   // Grant decision: open arbitration in IDLE, locked requester/TID during a burst.
   always_comb begin
      grant_valid_s = 1'b0;
      grantee_s     = '0;
      grant_tid_s   = '0;
      case (state_r)
         ST_IDLE: begin
            grantee_s     = req_sel_s;
            grant_tid_s   = free_tid_s;
            grant_valid_s = req_found_s & free_found_s & (outstanding_r < MAX_OUT_C);
         end
         ST_BURST: begin
            grantee_s     = burst_req_r;
            grant_tid_s   = burst_tid_r;
            grant_valid_s = req_valid_i[burst_req_r];
         end
         default: begin
            grant_valid_s = 1'b0;
         end
      endcase
      if (rst_i) begin
         grant_valid_s = 1'b0;
      end else begin
         grant_valid_s = grant_valid_s;
      end
   end

   assign hs_s      = grant_valid_s & mem_ready_i;
   assign alloc_s   = hs_s & (state_r == ST_IDLE);
   assign rsp_hit_s = rsp_valid_i & tid_busy_r[rsp_tid_i] & ~rst_i;
   assign free_s    = rsp_hit_s & rsp_last_i;

   // Request mux toward memory, per-requester ready and response steering.
   always_comb begin
      mem_valid_o = grant_valid_s;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      mem_we_o    = 1'b0;
      mem_last_o  = 1'b0;
      mem_tid_o   = '0;
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (grant_valid_s) begin
         mem_addr_o = req_addr_i[int'(grantee_s)*ADDR_W +: ADDR_W];
         mem_data_o = req_data_i[int'(grantee_s)*DATA_W +: DATA_W];
         mem_we_o   = req_we_i[grantee_s];
         mem_last_o = req_last_i[grantee_s];
         mem_tid_o  = grant_tid_s;
      end else begin
         mem_addr_o = '0;
      end
      for (int r = 0; r < NR_REQ; r++) begin
         req_ready_o[r] = hs_s & (grantee_s == PTR_W'(r));
         rsp_valid_o[r] = rsp_hit_s & (tid_owner_r[rsp_tid_i] == PTR_W'(r));
      end
   end

   // Arbitration FSM, TID table, in-flight count and sticky unexpected-response flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r       <= ST_IDLE;
         rr_ptr_r      <= '0;
         burst_req_r   <= '0;
         burst_tid_r   <= '0;
         tid_busy_r    <= '0;
         outstanding_r <= '0;
         unexp_r       <= 1'b0;
         for (int t = 0; t < NTID; t++) begin
            tid_owner_r[t] <= '0;
         end
      end else begin
         unexp_r <= unexp_r | (rsp_valid_i & ~tid_busy_r[rsp_tid_i]);
         if (free_s) begin
            tid_busy_r[rsp_tid_i] <= 1'b0;
         end
         if (alloc_s) begin
            tid_busy_r[grant_tid_s]  <= 1'b1;
            tid_owner_r[grant_tid_s] <= grantee_s;
         end
         case ({alloc_s, free_s})
            2'b10:   outstanding_r <= outstanding_r + 1'b1;
            2'b01:   outstanding_r <= outstanding_r - 1'b1;
            default: outstanding_r <= outstanding_r;
         endcase
         case (state_r)
            ST_IDLE: begin
               if (hs_s) begin
                  rr_ptr_r    <= rr_offset(grantee_s, 1);
                  burst_req_r <= grantee_s;
                  burst_tid_r <= grant_tid_s;
                  if (!req_last_i[grantee_s]) begin
                     state_r <= ST_BURST;
                  end
               end
            end
            ST_BURST: begin
               if (hs_s && req_last_i[burst_req_r]) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign outstanding_o = outstanding_r;
   assign unexp_rsp_o   = unexp_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized bench for mem_req_arbiter, checked against a cycle-level model built
// from TID ownership arrays and a requester rotation index.
module tb_mem_req_arbiter;

   localparam int NR   = 3;
   localparam int MAXO = 7;
   localparam int NT   = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  req_valid, req_we, req_last, req_ready;
   logic [NR*64-1:0] req_addr, req_data;
   logic           mem_valid, mem_ready, mem_we, mem_last;
   logic [63:0]    mem_addr, mem_data;
   logic [2:0]     mem_tid;
   logic           rsp_valid, rsp_last, unexp;
   logic [2:0]     rsp_tid;
   logic [NR-1:0]  rsp_vo;
   logic [3:0]     outstanding;

   int checks = 0;
   int errors = 0;

   // Model: TID busy/owner arrays, rotation index, burst lock, sticky flag.
   bit m_busy [NT];
   int m_owner [NT];
   int m_rr = 0;
   bit m_burst = 0;
   int m_breq = 0;
   int m_btid = 0;
   bit m_unexp = 0;
   int last_g, last_tid;

   always #5 clk = ~clk;

   mem_req_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_data_i(req_data), .req_last_i(req_last),
      .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
      .mem_we_o(mem_we), .mem_data_o(mem_data), .mem_last_o(mem_last), .mem_tid_o(mem_tid),
      .rsp_valid_i(rsp_valid), .rsp_tid_i(rsp_tid), .rsp_last_i(rsp_last),
      .rsp_valid_o(rsp_vo), .outstanding_o(outstanding), .unexp_rsp_o(unexp)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rand_payload();
      for (int r = 0; r < NR; r++) begin
         req_addr[r*64 +: 64] = {$urandom, $urandom};
         req_data[r*64 +: 64] = {$urandom, $urandom};
      end
   endtask

   // One clock: predict and compare combinational outputs, then advance the model.
   task automatic cycle();
      int g, tid, nbusy;
      logic [NR-1:0] e_rdy, e_rsp;
      #3;
      g = -1; tid = -1; nbusy = 0;
      foreach (m_busy[t]) nbusy += int'(m_busy[t]);
      if (!rst) begin
         if (m_burst) begin
            if (req_valid[m_breq]) begin g = m_breq; tid = m_btid; end
         end else if (nbusy < MAXO) begin
            for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) tid = t;
            for (int k = NR - 1; k >= 0; k--) if (req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
            if (g < 0 || tid < 0) begin g = -1; tid = -1; end
         end
      end
      check("mem_valid", 64'(mem_valid), 64'(g >= 0));
      if (g >= 0) begin
         check("mem_tid", 64'(mem_tid), 64'(tid));
         check("mem_addr", mem_addr, req_addr[g*64 +: 64]);
         check("mem_data", mem_data, req_data[g*64 +: 64]);
         check("mem_we", 64'(mem_we), 64'(req_we[g]));
         check("mem_last", 64'(mem_last), 64'(req_last[g]));
      end else begin
         check("idle_payload", {mem_addr[31:0], mem_data[29:0], mem_we, mem_last}, 64'd0);
      end
      e_rdy = (g >= 0 && mem_ready) ? NR'(1 << g) : '0;
      e_rsp = (!rst && rsp_valid && m_busy[rsp_tid]) ? NR'(1 << m_owner[rsp_tid]) : '0;
      check("req_ready", 64'(req_ready), 64'(e_rdy));
      check("rsp_valid_o", 64'(rsp_vo), 64'(e_rsp));
      check("outstanding", 64'(outstanding), 64'(nbusy));
      check("unexp", 64'(unexp), 64'(m_unexp));
      last_g   = (g >= 0 && mem_ready) ? g : -1;
      last_tid = (g >= 0 && mem_ready) ? tid : -1;
      @(posedge clk);
      if (rst) begin
         foreach (m_busy[t]) m_busy[t] = 1'b0;
         m_rr = 0; m_burst = 1'b0; m_unexp = 1'b0;
      end else begin
         if (rsp_valid) begin
            if (m_busy[rsp_tid]) begin
               if (rsp_last) m_busy[rsp_tid] = 1'b0;
            end else begin
               m_unexp = 1'b1;
            end
         end
         if (g >= 0 && mem_ready) begin
            if (!m_burst) begin
               m_busy[tid] = 1'b1; m_owner[tid] = g; m_rr = (g + 1) % NR;
               if (!req_last[g]) begin m_burst = 1'b1; m_breq = g; m_btid = tid; end
            end else if (req_last[g]) begin
               m_burst = 1'b0;
            end
         end
      end
      #1;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_last  = 1'b1;
      for (int t = 0; t < NT; t++) begin
         if (m_busy[t]) begin
            rsp_valid = 1'b1; rsp_tid = 3'(t);
            cycle();
         end
      end
      rsp_valid = 1'b0;
   endtask

   initial begin
      int t0;
      rst = 1'b1; req_valid = '0; req_we = '0; req_last = '1; req_addr = '0; req_data = '0;
      mem_ready = 1'b1; rsp_valid = 1'b0; rsp_tid = '0; rsp_last = 1'b0;
      @(posedge clk); #1;
      cycle();
      cycle();
      rst = 1'b0;

      // Three single-beat reads: grants 0,1,2 with TIDs 0,1,2.
      rand_payload();
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("s1_grant", 64'(last_g), 64'(i));
         check("s1_tid", 64'(last_tid), 64'(i));
      end
      req_valid = '0;
      check("s1_outstanding", 64'(outstanding), 64'd3);
      drain();

      // Requester 1 four-beat write while requester 0 waits.
      req_valid = 3'b001; cycle();
      req_valid = 3'b011; req_we = 3'b010;
      for (int b = 0; b < 4; b++) begin
         rand_payload();
         req_last = (b == 3) ? 3'b011 : 3'b001;
         cycle();
         if (b == 0) t0 = last_tid;
         check("s2_beat_grant", 64'(last_g), 64'd1);
         check("s2_beat_tid", 64'(last_tid), 64'(t0));
      end
      req_last = 3'b111; req_we = '0;
      cycle();
      check("s2_after_burst", 64'(last_g), 64'd0);
      drain();

      // Outstanding cap, then a freed TID reused one cycle later.
      req_valid = 3'b111;
      repeat (9) begin rand_payload(); cycle(); end
      check("s3_capped", 64'(mem_valid), 64'd0);
      check("s3_out7", 64'(outstanding), 64'd7);
      rsp_valid = 1'b1; rsp_tid = 3'd3; rsp_last = 1'b1;
      cycle();
      check("s3_no_same_cycle_reuse", 64'(last_g), 64'hFFFF_FFFF_FFFF_FFFF);
      rsp_valid = 1'b0;
      cycle();
      check("s3_tid_reuse", 64'(last_tid), 64'd3);
      check("s3_out_back", 64'(outstanding), 64'd7);
      drain();

      // Issue and free in the same cycle at five outstanding.
      req_valid = 3'b111;
      repeat (5) cycle();
      rsp_valid = 1'b1; rsp_tid = 3'd2; rsp_last = 1'b1;
      cycle();
      rsp_valid = 1'b0; req_valid = '0;
      check("s4_out_same", 64'(outstanding), 64'd5);
      drain();

      // Response for a free TID.
      rsp_valid = 1'b1; rsp_tid = 3'd6; rsp_last = 1'b1;
      cycle();
      rsp_valid = 1'b0;
      cycle();
      check("s5_unexp", 64'(unexp), 64'd1);

      // Randomized traffic.
      repeat (300) begin
         rand_payload();
         req_valid = NR'($urandom_range(0, 7));
         if (m_burst) req_valid[m_breq] = 1'b1;
         req_we = NR'($urandom_range(0, 7));
         for (int r = 0; r < NR; r++) req_last[r] = ($urandom_range(0, 3) != 0);
         mem_ready = ($urandom_range(0, 3) != 0);
         rsp_valid = ($urandom_range(0, 2) == 0);
         rsp_tid   = 3'($urandom_range(0, 7));
         rsp_last  = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rsp_valid = 1'b0; mem_ready = 1'b1; req_last = '1;
      if (m_burst) begin req_valid = '0; req_valid[m_breq] = 1'b1; cycle(); end
      drain();
      check("s6_unexp_sticky", 64'(unexp), 64'd1);

      // Reset on beat 2 of a 4-beat burst.
      req_valid = 3'b100; req_we = 3'b100; req_last = 3'b000;
      cycle();
      t0 = last_tid;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("s7_out_zero", 64'(outstanding), 64'd0);
      check("s7_unexp_cleared", 64'(unexp), 64'd0);
      req_valid = '0; rsp_valid = 1'b1; rsp_tid = 3'(t0); rsp_last = 1'b1;
      cycle();
      rsp_valid = 1'b0;
      check("s7_late_rsp", 64'(unexp), 64'd1);
      req_valid = 3'b111; req_we = '0; req_last = '1;
      cycle();
      check("s7_rr_zero", 64'(last_g), 64'd0);
      req_valid = '0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
